data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory controller sitting directly downstream of the MEM stage, replacing the behavioural RAM array currently modelled in the system bench. It accepts one load or store per request from MEM, performs big-endian byte/halfword/word lane handling with sign/zero extension, flags misaligned accesses, and can insert configurable wait states, stalling the pipeline through `busy`. A debug port lets the bench preload the array without using pipeline requests.

## Interface
- `DEPTH`, 32: number of 32-bit words, power of two, 2..1024
- `WAIT_STATES`, 0: extra cycles per access, 0..15
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_rd` in 1: load request (m_MEM read)
- `req_wr` in 1: store request (m_MEM write)
- `size` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- `sign_ext` in 1: 1 sign-extends byte/half loads, 0 zero-extends
- `addr` in 32: byte address (ALU result)
- `wdata` in 32: store data, right-justified for byte/half
- `dbg_we` in 1: debug write, full word, ignored when `busy`
- `dbg_addr` in 32: debug byte address, bits [1:0] ignored
- `dbg_wdata` in 32: debug write data
- `rdata` out 32: load result, valid with `rvalid`
- `rvalid` out 1: one-cycle pulse, load completed
- `wdone` out 1: one-cycle pulse, store committed
- `addr_err` out 1: one-cycle pulse, request rejected
- `busy` out 1: controller cannot accept; MEM must hold request

## Operation
- Request accepted on a cycle with (`req_rd` | `req_wr`) & !`busy`; inputs sampled only then.
- Word index = `addr[2 +: log2(DEPTH)]`; upper address bits ignored (wrap-around).
- Big-endian lanes: `addr[1:0]`=00 selects bits [31:24]; half at 00 → [31:16], at 10 → [15:0].
- Store: byte/half lanes written from `wdata[7:0]`/`wdata[15:0]`; other lanes unchanged.
- Load: selected lane right-justified, extended per `sign_ext`; word loads ignore `sign_ext`.
- Error (no array access, `addr_err` pulse, no `rvalid`/`wdone`): half with `addr[0]`=1, word with `addr[1:0]`≠00, `size`=11, or `req_rd` & `req_wr` both high.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on accept with WAIT_STATES=0 → DONE; else load counter with WAIT_STATES → WAIT.
  - WAIT: decrement; at 1 → DONE. `busy`=1.
  - DONE: perform write / capture read; pulse output; → IDLE. `busy`=0, and a new request may be accepted in DONE (back-to-back).
- Errors are decided at accept; error requests still traverse WAIT so timing is uniform.
- `dbg_we` writes in IDLE or DONE only; if coincident with a pipeline store to the same word, pipeline store wins.
- Load in DONE reads the array value after any store committed earlier, including the immediately preceding request (no stale data).

## Timing
- Reset values: `rdata`=0, `rvalid`=0, `wdone`=0, `addr_err`=0, `busy`=0, FSM=IDLE, counter=0. Array contents not reset.
- Accept at cycle T: `busy` high T+1..T+WAIT_STATES; result pulse (`rvalid`/`wdone`/`addr_err`) at T+1+WAIT_STATES; store visible to a load accepted at T+1+WAIT_STATES.
- WAIT_STATES=0: full throughput, one access per cycle, 1-cycle latency.
- `rdata` holds last load value until next `rvalid`.
- `rst` asserted mid-access: pending access aborted, no write, no pulse, outputs to reset values next edge.

## Structure
- Shared package `mips_pkg`: `mem_size_t` enum (BYTE, HALF, WORD), `dmem_state_t` enum (IDLE, WAIT, DONE).
- Sub-module `load_align`: combinational lane select + sign/zero extend (word, addr[1:0], size, sign_ext → 32-bit result); reused by any future uncached path.
- Array as `logic [31:0] mem [DEPTH]` with per-lane write enables.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x08, word load 0x08 → `wdone` at T+1, later `rvalid` with 0xDEADBEEF.
- Word 0x8899AABB at 0x10; lb 0x11 sign → 0xFFFFFF99; lbu 0x13 → 0x000000BB; lh 0x12 sign → 0xFFFFAABB.
- sb 0x5A to 0x16 over word 0x11223344 at 0x14 → word load 0x14 returns 0x11225A44.
- lw 0x0A, lh 0x05, `size`=11, rd&wr both high → each pulses `addr_err` only, memory unchanged.
- WAIT_STATES=3: store accepted T → `busy` T+1..T+3, `wdone` T+4; request held during busy accepted at T+4.
- Load accepted at T+2 of a 3-wait access, then `rst` → no `rvalid`, `busy`=0 next cycle, target word unchanged; address 0x84 with DEPTH=32 aliases word 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and helpers for the data-memory path.
package mips_pkg;

  // Access size encoding as driven by the MEM stage (2'b11 is reserved).
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

  // Lane write mask for a store. Bit 3 is bits [31:24], the lowest byte
  // address of the word (big-endian). Only meaningful for legal accesses.
  function automatic logic [3:0] store_lane_mask(input logic [1:0] size,
                                                 input logic [1:0] off);
    logic [3:0] m;
    case (size)
      BYTE:    m = 4'b1000 >> off;
      HALF:    m = off[1] ? 4'b0011 : 4'b1100;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian lane select and sign/zero extension for loads.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane and right-justify it with the requested extension.
  always_comb begin
    byte_v   = 8'h00;
    half_v   = 16'h0000;
    result_o = word_i;
    case (off_i)
      2'd0:    byte_v = word_i[31:24];
      2'd1:    byte_v = word_i[23:16];
      2'd2:    byte_v = word_i[15:8];
      default: byte_v = word_i[7:0];
    endcase
    half_v = off_i[1] ? word_i[15:0] : word_i[31:16];
    case (size_i)
      BYTE:    result_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
      HALF:    result_o = {{16{sign_ext_i & half_v[15]}}, half_v};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the MEM stage: one load/store per request,
// big-endian lanes, misalignment rejection, optional wait states and a
// debug preload port.
//
// Handshake: a request is taken on any cycle where (req_rd | req_wr) is high
// and busy is low; the MEM stage must hold the request unchanged while busy.
// Exactly one of rvalid / wdone / addr_err pulses per taken request,
// WAIT_STATES+1 cycles after it was taken.
module data_mem_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        wdone,
  output logic        addr_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [31:0] mem [DEPTH];

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request captured at accept, used when the access completes after waiting.
  logic          p_rd_q, p_err_q, p_sext_q;
  logic [1:0]    p_size_q, p_off_q;
  logic [AW-1:0] p_idx_q;
  logic [31:0]   p_wdata_q;

  logic        rvalid_q, wdone_q, addr_err_q;
  logic [31:0] rdata_q;

  logic          accept, req_err, fire;
  logic          f_rd, f_err, f_sext;
  logic [1:0]    f_size, f_off;
  logic [AW-1:0] f_idx;
  logic [31:0]   f_wdata;
  logic [3:0]    wmask;
  logic [31:0]   wword, load_val;
  logic          st_fire, ld_fire, dbg_fire;
  logic [AW-1:0] dbg_idx;
  logic          unused_addr_bits;

  assign busy    = (state_q == WAIT);
  assign accept  = (req_rd | req_wr) & ~busy;
  assign req_err = (req_rd & req_wr) | (size == 2'b11) |
                   ((size == HALF) & addr[0]) |
                   ((size == WORD) & (addr[1:0] != 2'b00));
  assign dbg_idx = dbg_addr[2 +: AW];
  assign unused_addr_bits = ^{addr[31:2+AW], dbg_addr[31:2+AW], dbg_addr[1:0]};

  // The access completes on the cycle it is taken (no wait states) or on the
  // last wait cycle; the array update and result registers share that edge.
  assign fire = (state_q == WAIT) ? (cnt_q == 4'd1) : (accept && (WAIT_STATES == 0));

  // Select the live request or the held one, depending on where we are.
  always_comb begin
    f_rd    = req_rd;
    f_err   = req_err;
    f_sext  = sign_ext;
    f_size  = size;
    f_off   = addr[1:0];
    f_idx   = addr[2 +: AW];
    f_wdata = wdata;
    if (state_q == WAIT) begin
      f_rd    = p_rd_q;
      f_err   = p_err_q;
      f_sext  = p_sext_q;
      f_size  = p_size_q;
      f_off   = p_off_q;
      f_idx   = p_idx_q;
      f_wdata = p_wdata_q;
    end
  end

  // Replicate store data across lanes; the mask picks which lanes land.
  always_comb begin
    wmask = store_lane_mask(f_size, f_off);
    case (f_size)
      BYTE:    wword = {4{f_wdata[7:0]}};
      HALF:    wword = {2{f_wdata[15:0]}};
      default: wword = f_wdata;
    endcase
  end

  assign st_fire  = fire & ~f_rd & ~f_err & ~rst;
  assign ld_fire  = fire & f_rd & ~f_err;
  // A pipeline store to the same word takes precedence over a debug write.
  assign dbg_fire = dbg_we & ~busy & ~rst & ~(st_fire & (dbg_idx == f_idx));

  load_align u_load_align (
    .word_i     (mem[f_idx]),
    .off_i      (f_off),
    .size_i     (f_size),
    .sign_ext_i (f_sext),
    .result_o   (load_val)
  );

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control state, held request and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      p_rd_q     <= 1'b0;
      p_err_q    <= 1'b0;
      p_sext_q   <= 1'b0;
      p_size_q   <= 2'b00;
      p_off_q    <= 2'b00;
      p_idx_q    <= '0;
      p_wdata_q  <= 32'h0;
      rvalid_q   <= 1'b0;
      wdone_q    <= 1'b0;
      addr_err_q <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= ld_fire;
      wdone_q    <= fire & ~f_rd & ~f_err;
      addr_err_q <= fire & f_err;
      if (ld_fire) rdata_q <= load_val;
      if (accept) begin
        p_rd_q    <= req_rd;
        p_err_q   <= req_err;
        p_sext_q  <= sign_ext;
        p_size_q  <= size;
        p_off_q   <= addr[1:0];
        p_idx_q   <= addr[2 +: AW];
        p_wdata_q <= wdata;
      end
    end
  end

  // Array writes: debug full-word writes and per-lane pipeline stores.
  always_ff @(posedge clk) begin
    if (dbg_fire) mem[dbg_idx] <= dbg_wdata;
    if (st_fire) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask[l]) mem[f_idx][8*l +: 8] <= wword[8*l +: 8];
      end
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign wdone    = wdone_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a zero-wait instance driven by a vector table and
// random traffic against a byte-addressed model, plus a three-wait instance
// exercised with hand-written stall and reset sequences.
module tb_data_mem_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with no wait states
  logic        rst, req_rd, req_wr, sign_ext, dbg_we;
  logic [1:0]  size;
  logic [31:0] addr, wdata, dbg_addr, dbg_wdata;
  logic [31:0] rdata;
  logic        rvalid, wdone, addr_err, busy;

  // Instance with three wait states
  logic        w_rst, w_req_rd, w_req_wr, w_sign_ext, w_dbg_we;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_dbg_addr, w_dbg_wdata;
  logic [31:0] w_rdata;
  logic        w_rvalid, w_wdone, w_addr_err, w_busy;

  data_mem_ctrl #(.DEPTH(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .rdata(rdata),
    .rvalid(rvalid), .wdone(wdone), .addr_err(addr_err), .busy(busy)
  );

  data_mem_ctrl #(.DEPTH(32), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(w_rst), .req_rd(w_req_rd), .req_wr(w_req_wr), .size(w_size),
    .sign_ext(w_sign_ext), .addr(w_addr), .wdata(w_wdata), .dbg_we(w_dbg_we),
    .dbg_addr(w_dbg_addr), .dbg_wdata(w_dbg_wdata), .rdata(w_rdata),
    .rvalid(w_rvalid), .wdone(w_wdone), .addr_err(w_addr_err), .busy(w_busy)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Memory as 128 bytes in address order; a word is four consecutive bytes
  // with the lowest address most significant.
  logic [7:0]  mb [128];
  logic [31:0] last_rd;

  task automatic model_dbg(input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a[6:2]) * 4;
    mb[b] = d[31:24]; mb[b+1] = d[23:16]; mb[b+2] = d[15:8]; mb[b+3] = d[7:0];
  endtask

  task automatic model_exec(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sx, input logic [31:0] ad, input logic [31:0] wd,
                            output logic e_rv, output logic e_wd, output logic e_err,
                            output logic [31:0] val);
    int a;
    a = int'(ad[6:0]);
    e_rv = 1'b0; e_wd = 1'b0; e_err = 1'b0; val = 32'h0;
    if (!rd && !wr) return;
    if ((rd && wr) || sz == 2'd3 || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0)) begin
      e_err = 1'b1;
      return;
    end
    if (wr) begin
      e_wd = 1'b1;
      if (sz == 2'd0) mb[a] = wd[7:0];
      else if (sz == 2'd1) begin mb[a] = wd[15:8]; mb[a+1] = wd[7:0]; end
      else begin mb[a] = wd[31:24]; mb[a+1] = wd[23:16]; mb[a+2] = wd[15:8]; mb[a+3] = wd[7:0]; end
    end else begin
      e_rv = 1'b1;
      if (sz == 2'd0) val = {{24{sx & mb[a][7]}}, mb[a]};
      else if (sz == 2'd1) val = {{16{sx & mb[a][7]}}, mb[a], mb[a+1]};
      else val = {mb[a], mb[a+1], mb[a+2], mb[a+3]};
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_a(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sx, input logic [31:0] ad, input logic [31:0] wd);
    req_rd = rd; req_wr = wr; size = sz; sign_ext = sx; addr = ad; wdata = wd;
    dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
  endtask

  // Advance one edge and compare the zero-wait instance's outputs.
  task automatic check_a(input string tag, input logic e_rv, input logic e_wd,
                         input logic e_err, input logic [31:0] e_val);
    tick();
    if (e_rv) last_rd = e_val;
    chk({tag, " rvalid"}, 32'(rvalid), 32'(e_rv));
    chk({tag, " wdone"}, 32'(wdone), 32'(e_wd));
    chk({tag, " addr_err"}, 32'(addr_err), 32'(e_err));
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " rdata"}, rdata, last_rd);
  endtask

  task automatic w_drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
    w_req_rd = rd; w_req_wr = wr; w_size = sz; w_sign_ext = 1'b0; w_addr = ad; w_wdata = wd;
  endtask

  task automatic w_idle();
    w_drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic w_dbg(input logic [31:0] a, input logic [31:0] d);
    w_dbg_we = 1'b1; w_dbg_addr = a; w_dbg_wdata = d;
    tick();
    w_dbg_we = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        e_rv;
    logic        e_wd;
    logic        e_err;
    logic [31:0] e_val;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v_st(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    vec_t v;
    v = '{rd: 1'b0, wr: 1'b1, sz: sz, sx: 1'b0, ad: ad, wd: wd,
          e_rv: 1'b0, e_wd: 1'b1, e_err: 1'b0, e_val: 32'h0};
    return v;
  endfunction

  function automatic vec_t v_ld(input logic [1:0] sz, input logic sx, input logic [31:0] ad, input logic [31:0] ev);
    vec_t v;
    v = '{rd: 1'b1, wr: 1'b0, sz: sz, sx: sx, ad: ad, wd: 32'h0,
          e_rv: 1'b1, e_wd: 1'b0, e_err: 1'b0, e_val: ev};
    return v;
  endfunction

  function automatic vec_t v_er(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] ad);
    vec_t v;
    v = '{rd: rd, wr: wr, sz: sz, sx: 1'b1, ad: ad, wd: 32'hFFFF_FFFF,
          e_rv: 1'b0, e_wd: 1'b0, e_err: 1'b1, e_val: 32'h0};
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic        e_rv, e_wd, e_err;
    logic [31:0] e_val, d;
    logic        r_rd, r_wr, r_sx;
    logic [1:0]  r_sz;
    logic [31:0] r_ad, r_wd;
    int          op;

    drive_a(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    w_idle();
    w_dbg_we = 1'b0; w_dbg_addr = 32'h0; w_dbg_wdata = 32'h0;
    last_rd = 32'h0;
    rst = 1'b1; w_rst = 1'b1;
    repeat (3) tick();

    chk("reset rdata", rdata, 32'h0);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset wdone", 32'(wdone), 32'h0);
    chk("reset addr_err", 32'(addr_err), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("w reset busy", 32'(w_busy), 32'h0);
    chk("w reset rdata", w_rdata, 32'h0);
    rst = 1'b0; w_rst = 1'b0;
    tick();

    // Preload the whole zero-wait array through the debug port.
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      dbg_we = 1'b1; dbg_addr = 32'(i * 4) | 32'(i & 3); dbg_wdata = d;
      model_dbg(32'(i * 4), d);
      tick();
    end
    dbg_we = 1'b0;

    tbl.push_back(v_st(2'd2, 32'h08, 32'hDEADBEEF));
    tbl.push_back(v_ld(2'd2, 1'b0, 32'h08, 32'hDEADBEEF));
    tbl.push_back(v_st(2'd2, 32'h10, 32'h8899AABB));
    tbl.push_back(v_ld(2'd0, 1'b1, 32'h11, 32'hFFFFFF99));
    tbl.push_back(v_ld(2'd0, 1'b0, 32'h13, 32'h000000BB));
    tbl.push_back(v_ld(2'd1, 1'b1, 32'h12, 32'hFFFFAABB));
    tbl.push_back(v_ld(2'd1, 1'b0, 32'h10, 32'h00008899));
    tbl.push_back(v_ld(2'd2, 1'b1, 32'h10, 32'h8899AABB));
    tbl.push_back(v_ld(2'd0, 1'b1, 32'h12, 32'hFFFFFFAA));
    tbl.push_back(v_st(2'd2, 32'h14, 32'h11223344));
    tbl.push_back(v_st(2'd0, 32'h16, 32'hFFFFFF5A));
    tbl.push_back(v_ld(2'd2, 1'b0, 32'h14, 32'h11225A44));
    tbl.push_back(v_er(1'b1, 1'b0, 2'd2, 32'h0A));
    tbl.push_back(v_er(1'b1, 1'b0, 2'd1, 32'h05));
    tbl.push_back(v_er(1'b1, 1'b0, 2'd3, 32'h10));
    tbl.push_back(v_er(1'b1, 1'b1, 2'd2, 32'h10));
    tbl.push_back(v_er(1'b0, 1'b1, 2'd2, 32'h16));
    tbl.push_back(v_er(1'b0, 1'b1, 2'd3, 32'h14));
    tbl.push_back(v_er(1'b0, 1'b1, 2'd1, 32'h11));
    tbl.push_back(v_ld(2'd2, 1'b0, 32'h14, 32'h11225A44));
    tbl.push_back(v_ld(2'd2, 1'b0, 32'h10, 32'h8899AABB));
    tbl.push_back(v_st(2'd1, 32'h12, 32'hABCD1234));
    tbl.push_back(v_ld(2'd2, 1'b0, 32'h10, 32'h88991234));
    tbl.push_back(v_st(2'd2, 32'h84, 32'hCAFEF00D));
    tbl.push_back(v_ld(2'd2, 1'b0, 32'h04, 32'hCAFEF00D));
    tbl.push_back(v_ld(2'd0, 1'b0, 32'h07, 32'h0000000D));
    tbl.push_back(v_st(2'd1, 32'h10, 32'h0000F00F));
    tbl.push_back(v_ld(2'd1, 1'b1, 32'h10, 32'hFFFFF00F));

    // Back-to-back, one request per cycle; the model follows along so the
    // random phase starts from the same memory image.
    foreach (tbl[i]) begin
      drive_a(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].ad, tbl[i].wd);
      model_exec(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].ad, tbl[i].wd,
                 e_rv, e_wd, e_err, e_val);
      check_a($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_wd, tbl[i].e_err, tbl[i].e_val);
    end

    // Debug write coincident with a pipeline store to the same word.
    drive_a(1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'h11111111);
    dbg_we = 1'b1; dbg_addr = 32'h08; dbg_wdata = 32'h22222222;
    model_dbg(32'h08, 32'h22222222);
    model_exec(1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'h11111111, e_rv, e_wd, e_err, e_val);
    check_a("dbg_vs_store", 1'b0, 1'b1, 1'b0, 32'h0);
    drive_a(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    check_a("dbg_vs_store_ld", 1'b1, 1'b0, 1'b0, 32'h11111111);

    // Random traffic against the byte model.
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      r_rd = (op < 4) || (op == 8);
      r_wr = (op >= 4 && op < 8) || (op == 8);
      r_sz = ($urandom_range(0, 7) != 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      r_ad = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (r_sz == 2'd1) r_ad = r_ad & ~32'h1;
        if (r_sz == 2'd2) r_ad = r_ad & ~32'h3;
      end
      r_sx = 1'($urandom_range(0, 1));
      r_wd = $urandom;
      drive_a(r_rd, r_wr, r_sz, r_sx, r_ad, r_wd);
      if (op == 9 && $urandom_range(0, 1) == 1) begin
        d = $urandom;
        dbg_we = 1'b1; dbg_addr = $urandom; dbg_wdata = d;
        model_dbg(dbg_addr, d);
      end
      model_exec(r_rd, r_wr, r_sz, r_sx, r_ad, r_wd, e_rv, e_wd, e_err, e_val);
      check_a($sformatf("rnd%0d", n), e_rv, e_wd, e_err, e_val);
    end
    drive_a(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

    // ----- three wait states -----
    w_dbg(32'h04, 32'hA5A5A5A5);
    w_dbg(32'h20, 32'h00000000);

    // Store held through busy is taken again when busy drops.
    w_drive(1'b0, 1'b1, 2'd2, 32'h20, 32'h55667788);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) w_idle();
      if (k == 6) begin w_dbg_we = 1'b1; w_dbg_addr = 32'h20; w_dbg_wdata = 32'hFFFFFFFF; end
      if (k == 7) w_dbg_we = 1'b0;
      chk($sformatf("ws store busy k%0d", k), 32'(w_busy),
          32'((k >= 1 && k <= 3) || (k >= 5 && k <= 7)));
      chk($sformatf("ws store wdone k%0d", k), 32'(w_wdone), 32'(k == 4 || k == 8));
    end
    w_drive(1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) w_idle();
      chk($sformatf("ws load rvalid k%0d", k), 32'(w_rvalid), 32'(k == 4));
    end
    chk("ws load rdata", w_rdata, 32'h55667788);

    // Misaligned load still spends the wait cycles.
    w_drive(1'b1, 1'b0, 2'd2, 32'h22, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) w_idle();
      chk($sformatf("ws err busy k%0d", k), 32'(w_busy), 32'(k <= 3));
      chk($sformatf("ws err pulse k%0d", k), 32'(w_addr_err), 32'(k == 4));
      chk($sformatf("ws err rvalid k%0d", k), 32'(w_rvalid), 32'h0);
    end

    // Store to 0x84 (aliases word 1) aborted by reset.
    w_drive(1'b0, 1'b1, 2'd2, 32'h84, 32'h12345678);
    tick();
    w_idle();
    tick();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    chk("ws rst st busy", 32'(w_busy), 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ws rst st wdone%0d", k), 32'(w_wdone), 32'h0);
      tick();
    end
    w_drive(1'b1, 1'b0, 2'd2, 32'h04, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) w_idle();
    end
    chk("ws alias rvalid", 32'(w_rvalid), 32'h1);
    chk("ws alias unchanged", w_rdata, 32'hA5A5A5A5);

    // Load aborted by reset: no pulse, rdata back to zero.
    tick();
    w_drive(1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
    tick();
    w_idle();
    tick();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    chk("ws rst ld busy", 32'(w_busy), 32'h0);
    chk("ws rst ld rdata", w_rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ws rst ld rvalid%0d", k), 32'(w_rvalid), 32'h0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
